// File: rtl/wb_wbuf_arbiter_pkg.sv
// Shared definitions for the two-requester write-buffer arbiter.
// Holds the state encoding and the default burst limit.
package wb_arb_pkg;

  localparam int unsigned MaxBurstDefault = 8;
  localparam int unsigned CntW            = 8;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StGrant = 2'd1,
    StFlush = 2'd2,
    StRead  = 2'd3
  } arb_state_e;

endpackage

// File: rtl/wb_wbuf_arbiter_if.sv
// Classic Wishbone bus bundle. The master drives the address, write data and
// controls; the slave returns read data and ack.
interface wb_wbuf_arbiter_if;
  logic [31:0] adr;
  logic [31:0] wdat;
  logic [31:0] rdat;
  logic [3:0]  sel;
  logic        cyc;
  logic        stb;
  logic        we;
  logic        ack;

  modport master (output adr, wdat, sel, cyc, stb, we, input rdat, ack);
  modport slave  (input adr, wdat, sel, cyc, stb, we, output rdat, ack);
endinterface

// File: rtl/wb_wbuf_rrpick.sv
// Round-robin choice between two requesters: 0 selects A, 1 selects B.
// On a tie the requester that did not win last time is picked.
module wb_wbuf_rrpick (
  input  logic reqa,
  input  logic reqb,
  input  logic lastgnt,
  output logic pick
);

  always_comb begin
    pick = 1'b0;
    if (reqa && reqb) begin
      pick = ~lastgnt;
    end else if (reqb) begin
      pick = 1'b1;
    end
  end

endmodule

// File: rtl/wb_wbuf_arbiter.sv
// Two-requester Wishbone arbiter in front of a write buffer. Writes pass straight
// through; reads first flush the buffer so they never observe stale data.
module wb_wbuf_arbiter
  import wb_arb_pkg::*;
#(
  parameter int unsigned MAXBURST = MaxBurstDefault
) (
  input  logic               clock,
  input  logic               sclr,
  wb_wbuf_arbiter_if.slave   a_if,
  wb_wbuf_arbiter_if.slave   b_if,
  wb_wbuf_arbiter_if.master  m_if,
  output logic               flushreq_o,
  input  logic               flushack_i
);

  localparam logic [CntW-1:0] MaxCnt = CntW'(MAXBURST);

  arb_state_e      r_state, w_state_nxt;
  logic            r_gnt, w_gnt_nxt;
  logic            r_lastgnt, w_lastgnt_nxt;
  logic [CntW-1:0] r_cnt, w_cnt_nxt;
  logic            w_new_grant;
  logic            w_ack;
  logic            w_pick;
  logic            w_reqa, w_reqb, w_other_req;
  logic            w_g_cyc, w_g_stb, w_g_we;
  logic [31:0]     w_g_adr, w_g_dat;
  logic [3:0]      w_g_sel;

  assign w_reqa      = a_if.cyc & a_if.stb;
  assign w_reqb      = b_if.cyc & b_if.stb;
  assign w_other_req = r_gnt ? w_reqa : w_reqb;

  assign w_g_cyc = r_gnt ? b_if.cyc  : a_if.cyc;
  assign w_g_stb = r_gnt ? b_if.stb  : a_if.stb;
  assign w_g_we  = r_gnt ? b_if.we   : a_if.we;
  assign w_g_adr = r_gnt ? b_if.adr  : a_if.adr;
  assign w_g_dat = r_gnt ? b_if.wdat : a_if.wdat;
  assign w_g_sel = r_gnt ? b_if.sel  : a_if.sel;

  wb_wbuf_rrpick u_rrpick (
    .reqa    (w_reqa),
    .reqb    (w_reqb),
    .lastgnt (r_lastgnt),
    .pick    (w_pick)
  );

  always_ff @(posedge clock or posedge sclr) begin
    if (sclr) begin
      r_state   <= StIdle;
      r_gnt     <= 1'b0;
      r_lastgnt <= 1'b1;
      r_cnt     <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_gnt     <= w_gnt_nxt;
      r_lastgnt <= w_lastgnt_nxt;
      r_cnt     <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_gnt_nxt     = r_gnt;
    w_lastgnt_nxt = r_lastgnt;
    w_new_grant   = 1'b0;
    w_ack         = 1'b0;
    flushreq_o    = 1'b0;
    m_if.adr      = a_if.adr;
    m_if.wdat     = a_if.wdat;
    m_if.sel      = a_if.sel;
    m_if.cyc      = 1'b0;
    m_if.stb      = 1'b0;
    m_if.we       = 1'b0;

    unique case (r_state)
      StIdle: begin
        if (w_reqa || w_reqb) begin
          w_state_nxt   = StGrant;
          w_gnt_nxt     = w_pick;
          w_lastgnt_nxt = w_pick;
          w_new_grant   = 1'b1;
        end
      end
      StGrant: begin
        m_if.adr  = w_g_adr;
        m_if.wdat = w_g_dat;
        m_if.sel  = w_g_sel;
        m_if.cyc  = w_g_cyc;
        m_if.we   = w_g_cyc & w_g_we;
        if (!w_g_cyc) begin
          w_state_nxt = StIdle;
        end else if (r_cnt == MaxCnt && w_other_req) begin
          // Burst used up while the other side waits: stall and re-arbitrate.
          w_state_nxt = StIdle;
        end else if (w_g_stb && !w_g_we) begin
          w_state_nxt = StFlush;
        end else begin
          m_if.stb = w_g_stb;
          w_ack    = w_g_stb & m_if.ack;
        end
      end
      StFlush: begin
        m_if.adr   = w_g_adr;
        m_if.wdat  = w_g_dat;
        m_if.sel   = w_g_sel;
        m_if.cyc   = w_g_cyc;
        m_if.we    = w_g_cyc & w_g_we;
        flushreq_o = w_g_cyc;
        if (!w_g_cyc) begin
          w_state_nxt = StIdle;
        end else if (flushack_i) begin
          w_state_nxt = StRead;
        end
      end
      StRead: begin
        m_if.adr   = w_g_adr;
        m_if.wdat  = w_g_dat;
        m_if.sel   = w_g_sel;
        m_if.cyc   = w_g_cyc;
        m_if.stb   = w_g_cyc & w_g_stb;
        m_if.we    = w_g_cyc & w_g_we;
        flushreq_o = w_g_cyc;
        w_ack      = w_g_cyc & w_g_stb & m_if.ack;
        if (!w_g_cyc) begin
          w_state_nxt = StIdle;
        end else if (m_if.ack) begin
          w_state_nxt = StGrant;
        end
      end
      default: begin
        w_state_nxt = StIdle;
      end
    endcase

    w_cnt_nxt = r_cnt;
    if (w_new_grant) begin
      w_cnt_nxt = '0;
    end else if (w_ack && r_cnt != MaxCnt) begin
      w_cnt_nxt = r_cnt + CntW'(1);
    end
  end

  assign a_if.ack  = w_ack & ~r_gnt;
  assign b_if.ack  = w_ack & r_gnt;
  assign a_if.rdat = m_if.rdat;
  assign b_if.rdat = m_if.rdat;

endmodule
